// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns the select of a shared N_REQ-to-1 mux.
// The grant is held until downstream accepts it; the next winner is chosen in the accepting cycle.
module rr_mux_arbiter #(
    parameter int N_REQ = 2,
    parameter int SELW  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [SELW-1:0]  sel,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   ptr_nxt;
    logic [N_REQ-1:0]  masked;
    logic [SELW:0]     win;

    // Returns {found, index}: first set bit scanning p, p+1, ..., wrapping at N_REQ.
    function automatic logic [SELW:0] pick_winner(input logic [N_REQ-1:0] r,
                                                  input logic [SELW-1:0]  p);
        logic [2*N_REQ-1:0] rot;
        logic               found;
        int                 idx;
        rot   = {r, r} >> p;
        found = 1'b0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = int'(p) + k;
            end
        end
        if (idx >= N_REQ) begin
            idx = idx - N_REQ;
        end
        return {found, SELW'(idx)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        ptr_nxt = ptr_q;
        masked  = req;
        win     = '0;
        ack     = '0;
        case (state_q)
            IDLE: begin
                win = pick_winner(req, ptr_q);
                if (win[SELW]) begin
                    sel_d   = win[SELW-1:0];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    ack[sel_q]     = 1'b1;
                    ptr_nxt        = (sel_q == SELW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
                    ptr_d          = ptr_nxt;
                    // The served requester is excluded so a re-request cannot win back-to-back.
                    masked[sel_q]  = 1'b0;
                    win            = pick_winner(masked, ptr_nxt);
                    if (win[SELW]) begin
                        sel_d = win[SELW-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel       = sel_q;
    assign out_valid = (state_q == BUSY);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and random checks of rr_mux_arbiter (N_REQ=5) against a cycle-level reference model.
module tb_rr_mux_arbiter;

    localparam int N  = 5;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  ack;
    logic [SW-1:0] sel;
    logic          out_valid;
    logic          out_ready;

    rr_mux_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  ack;
        logic [SW-1:0] sel;
        logic          valid;
    } exp_t;

    exp_t          sb[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            m_busy, m_sel, m_ptr;
    logic [N-1:0]  obs_ack;
    logic [SW-1:0] obs_sel;
    logic          obs_valid;
    int            wait_cnt[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int scan(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_next(input logic [N-1:0] r, input logic rd);
        int           np;
        int           w;
        logic [N-1:0] mk;
        if (m_busy != 0 && rd) begin
            np        = (m_sel + 1) % N;
            mk        = r;
            mk[m_sel] = 1'b0;
            m_ptr     = np;
            w         = scan(mk, np);
            if (w >= 0) m_sel = w;
            else        m_busy = 0;
        end else if (m_busy == 0) begin
            w = scan(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1;
                m_sel  = w;
            end
        end
    endtask

    // Drive one cycle's inputs, compare outputs mid-cycle, then advance the model past the edge.
    task automatic apply(input logic [N-1:0] r, input logic rd);
        exp_t e;
        exp_t got;
        req       = r;
        out_ready = rd;
        e.valid   = (m_busy != 0);
        e.sel     = SW'(m_sel);
        e.ack     = (m_busy != 0 && rd) ? (N'(1) << m_sel) : '0;
        sb.push_back(e);
        #1;
        obs_ack   = ack;
        obs_sel   = sel;
        obs_valid = out_valid;
        got       = sb.pop_front();
        check("ack", 32'(obs_ack), 32'(got.ack));
        check("sel", 32'(obs_sel), 32'(got.sel));
        check("valid", 32'(obs_valid), 32'(got.valid));
        check("inv_onehot", 32'($onehot0(obs_ack)), 32'(1));
        check("inv_ack_hs", 32'((obs_ack == '0) || (obs_valid && out_ready)), 32'(1));
        check("inv_sel_range", 32'(int'(obs_sel) < N), 32'(1));
        @(posedge clk);
        model_next(r, rd);
    endtask

    task automatic step(input logic [N-1:0] r, input logic rd);
        @(negedge clk);
        apply(r, rd);
    endtask

    initial begin
        int           seq2[6];
        logic [N-1:0] cur;
        logic [N-1:0] last_ack;
        seq2      = '{0, 1, 2, 3, 4, 0};
        rst_n     = 1'b0;
        req       = '1;
        out_ready = 1'b1;
        m_busy    = 0;
        m_sel     = 0;
        m_ptr     = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Reset held with all requests pending
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_sel", 32'(sel), 32'(0));
        check("rst_ack", 32'(ack), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        apply(5'b11111, 1'b0);
        #1;
        check("rel_valid", 32'(out_valid), 32'(1));
        check("rel_sel", 32'(sel), 32'(0));

        // Full rotation, back-to-back grants
        for (int i = 0; i < 6; i++) begin
            step(5'b11111, 1'b1);
            check("rot_sel", 32'(obs_sel), 32'(seq2[i]));
            check("rot_ack", 32'(obs_ack), 32'(5'b00001 << seq2[i]));
        end
        step(5'b11110, 1'b1);
        step(5'b11100, 1'b1);
        step(5'b11000, 1'b1);
        step(5'b10000, 1'b1);

        // Top requester alone, pointer wraps to 0, then idle
        step(5'b10000, 1'b1);
        step(5'b10000, 1'b1);
        check("top_sel", 32'(obs_sel), 32'(4));
        check("top_ack", 32'(obs_ack), 32'(5'b10000));
        step(5'b00000, 1'b1);
        check("top_idle", 32'(obs_valid), 32'(0));
        step(5'b10001, 1'b1);
        step(5'b10001, 1'b1);
        check("wrap_sel", 32'(obs_sel), 32'(0));
        check("wrap_ack", 32'(obs_ack), 32'(5'b00001));
        step(5'b10000, 1'b1);

        // Stall on grant 1 while requester 0 arrives
        step(5'b00010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(5'b00011, 1'b0);
            check("stall_sel", 32'(obs_sel), 32'(1));
            check("stall_ack", 32'(obs_ack), 32'(0));
        end
        step(5'b00011, 1'b1);
        check("unstall_ack", 32'(obs_ack), 32'(5'b00010));
        #1;
        check("unstall_next_sel", 32'(sel), 32'(0));
        check("unstall_next_valid", 32'(out_valid), 32'(1));

        // Asynchronous reset between edges while stalled
        step(5'b00001, 1'b0);
        #3;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'(0));
        check("arst_ack", 32'(ack), 32'(0));
        check("arst_sel", 32'(sel), 32'(0));
        m_busy = 0;
        m_sel  = 0;
        m_ptr  = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(5'b10001, 1'b1);
        #1;
        check("arst_ptr_sel", 32'(sel), 32'(0));
        step(5'b10001, 1'b1);
        check("arst_ptr_ack", 32'(obs_ack), 32'(5'b00001));
        step(5'b10000, 1'b1);

        // Random traffic obeying the hold-until-ack protocol
        cur      = '0;
        last_ack = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(cur[i] && !last_ack[i])) cur[i] = ($urandom_range(0, 2) != 0);
            end
            step(cur, ($urandom_range(0, 3) != 0));
            for (int i = 0; i < N; i++) begin
                if (obs_ack[i]) begin
                    check("fairness", 32'(wait_cnt[i] <= N - 1), 32'(1));
                    wait_cnt[i] = 0;
                end else if (cur[i] && obs_ack != '0) begin
                    wait_cnt[i]++;
                end
            end
            last_ack = obs_ack;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
